// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared symbol codes, segment patterns and FSM state type for
// the 7-segment scan decoder and any future encoder-check logic.
package seg_scan_pkg;

    // Symbol codes beyond the decimal digits
    localparam logic [3:0] SYM_MINUS   = 4'd10;
    localparam logic [3:0] SYM_BLANK   = 4'd11;
    localparam logic [3:0] SYM_INVALID = 4'd15;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] PAT_0     = 7'h40;
    localparam logic [6:0] PAT_1     = 7'h79;
    localparam logic [6:0] PAT_2     = 7'h24;
    localparam logic [6:0] PAT_3     = 7'h30;
    localparam logic [6:0] PAT_4     = 7'h19;
    localparam logic [6:0] PAT_5     = 7'h12;
    localparam logic [6:0] PAT_6     = 7'h02;
    localparam logic [6:0] PAT_7     = 7'h78;
    localparam logic [6:0] PAT_8     = 7'h00;
    localparam logic [6:0] PAT_9     = 7'h10;
    localparam logic [6:0] PAT_MINUS = 7'h3F;
    localparam logic [6:0] PAT_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } scan_state_t;

    // True when exactly one anode enable is driven low
    function automatic logic is_one_cold(input logic [3:0] en);
        return (en == 4'b1110) || (en == 4'b1101) ||
               (en == 4'b1011) || (en == 4'b0111);
    endfunction

    // Digit index selected by a one-cold enable
    function automatic logic [1:0] slot_of(input logic [3:0] en);
        logic [1:0] idx;
        idx = 2'd0;
        case (en)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational lookup from a 7-bit active-low segment
// pattern to its 4-bit symbol code; unknown patterns map to SYM_INVALID.
module seg_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic [3:0] o_sym
);

    // Pattern-to-symbol table
    always_comb begin
        // NOTE: default assigned first so every path drives o_sym and no latch is inferred.
        o_sym = SYM_INVALID;
        case (i_pat)
            PAT_0:     o_sym = 4'd0;
            PAT_1:     o_sym = 4'd1;
            PAT_2:     o_sym = 4'd2;
            PAT_3:     o_sym = 4'd3;
            PAT_4:     o_sym = 4'd4;
            PAT_5:     o_sym = 4'd5;
            PAT_6:     o_sym = 4'd6;
            PAT_7:     o_sym = 4'd7;
            PAT_8:     o_sym = 4'd8;
            PAT_9:     o_sym = 4'd9;
            PAT_MINUS: o_sym = SYM_MINUS;
            PAT_BLANK: o_sym = SYM_BLANK;
            default:   o_sym = SYM_INVALID;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a multiplexed 4-digit 7-segment bus, waits for
// each digit slot to settle, decodes it and publishes coherent 4-digit frames.
// Optional macro SCAN_ORDER_CHECK_EN enforces capture order 0->1->2->3 and
// adds the order_err pulse output.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  disp,
    input  logic [3:0]  enable,
    output logic [15:0] codes,
    output logic        is_neg,
    output logic        frame_valid,
    output logic        err,
    output logic        stale
`ifdef SCAN_ORDER_CHECK_EN
    ,
    output logic        order_err
`endif
);

    localparam logic [7:0]      SETTLE_LIM = 8'(SETTLE_CYC);
    localparam int              TO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIM     = TO_W'(TIMEOUT_CYC);

    // Input synchronisers and one-cycle history
    logic [3:0]  r_en_s1, r_en_s2, r_en_prev;
    logic [7:0]  r_disp_s1, r_disp_s2, r_disp_prev;

    // Slot FSM
    scan_state_t r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next, w_cnt_inc;
    logic        w_changed, w_one_cold;

    // Capture path and frame assembly
    logic        w_capture, w_accept, w_frame_done;
    logic [1:0]  w_cap_slot;
    logic [3:0]  w_cap_sym;
    logic [3:0]  r_seen, w_seen_next;
    logic [15:0] r_shadow;
    logic        w_any_neg, w_any_inv;

    // Published frame and timeout
    logic [15:0]     r_codes;
    logic            r_is_neg, r_frame_valid, r_err, r_stale;
    logic [TO_W-1:0] r_to_cnt;

`ifdef SCAN_ORDER_CHECK_EN
    logic [1:0] r_expect;
    logic       r_order_err;
    logic       w_in_order, w_order_viol;
`endif

    // Two-stage input registers plus the previous registered value for change detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_s1     <= 4'hF;
            r_en_s2     <= 4'hF;
            r_en_prev   <= 4'hF;
            r_disp_s1   <= 8'hFF;
            r_disp_s2   <= 8'hFF;
            r_disp_prev <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignments let each stage take the old value of the one before it.
            r_en_s1     <= enable;
            r_en_s2     <= r_en_s1;
            r_en_prev   <= r_en_s2;
            r_disp_s1   <= disp;
            r_disp_s2   <= r_disp_s1;
            r_disp_prev <= r_disp_s2;
        end
    end

    assign w_changed  = {r_en_s2, r_disp_s2} != {r_en_prev, r_disp_prev};
    assign w_one_cold = is_one_cold(r_en_s2);
    assign w_cnt_inc  = r_cnt + 8'd1;

    // State and settle-counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: count stable cycles, capture once, hold until the bus moves
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_one_cold) begin
                    w_state_next = SETTLE;
                    w_cnt_next   = 8'd1;
                end else begin
                    w_cnt_next   = 8'd0;
                end
            end
            SETTLE: begin
                if (w_changed) begin
                    if (w_one_cold) begin
                        w_cnt_next   = 8'd1;
                    end else begin
                        w_state_next = IDLE;
                        w_cnt_next   = 8'd0;
                    end
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc >= SETTLE_LIM) begin
                        w_state_next = CAPTURE;
                    end
                end
            end
            CAPTURE, HOLD: begin
                if (w_changed) begin
                    if (w_one_cold) begin
                        w_state_next = SETTLE;
                        w_cnt_next   = 8'd1;
                    end else begin
                        w_state_next = IDLE;
                        w_cnt_next   = 8'd0;
                    end
                end else begin
                    w_state_next = HOLD;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    // The settled pair is the previous registered value while in CAPTURE
    assign w_capture  = (r_state == CAPTURE);
    assign w_cap_slot = slot_of(r_en_prev);

    seg_pattern_decode u_decode (
        .i_pat (r_disp_prev[6:0]),
        .o_sym (w_cap_sym)
    );

    assign w_frame_done = (r_seen == 4'hF);

`ifdef SCAN_ORDER_CHECK_EN
    assign w_in_order   = (w_cap_slot == r_expect);
    assign w_order_viol = w_capture && !w_in_order;
    assign w_accept     = w_capture && (w_in_order || (w_cap_slot == 2'd0));
`else
    assign w_accept     = w_capture;
`endif

    // Seen-mask update: cleared on frame completion or order violation, then set by an accepted capture
    always_comb begin
        w_seen_next = w_frame_done ? 4'h0 : r_seen;
`ifdef SCAN_ORDER_CHECK_EN
        if (w_order_viol) begin
            w_seen_next = 4'h0;
        end
`endif
        if (w_accept) begin
            w_seen_next[w_cap_slot] = 1'b1;
        end
    end

    // Frame flags derived from the assembled shadow
    always_comb begin
        w_any_neg = 1'b0;
        w_any_inv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_shadow[4*i +: 4] == SYM_MINUS)   w_any_neg = 1'b1;
            if (r_shadow[4*i +: 4] == SYM_INVALID) w_any_inv = 1'b1;
        end
    end

    // Shadow frame and seen mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shadow is reset so a frame interrupted by rst can never leak stale digits.
            r_shadow <= {4{SYM_BLANK}};
            r_seen   <= 4'h0;
        end else begin
            r_seen <= w_seen_next;
            if (w_accept) begin
                r_shadow[{w_cap_slot, 2'b00} +: 4] <= w_cap_sym;
            end
        end
    end

`ifdef SCAN_ORDER_CHECK_EN
    // Expected next slot and violation pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expect    <= 2'd0;
            r_order_err <= 1'b0;
        end else begin
            r_order_err <= w_order_viol;
            if (w_accept) begin
                r_expect <= w_cap_slot + 2'd1;
            end else if (w_order_viol) begin
                r_expect <= 2'd0;
            end
        end
    end

    assign order_err = r_order_err;
`endif

    // Frame publication and saturating timeout; a completing frame beats the timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_codes       <= {4{SYM_BLANK}};
            r_is_neg      <= 1'b0;
            r_err         <= 1'b0;
            r_frame_valid <= 1'b0;
            r_stale       <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_codes  <= r_shadow;
                r_is_neg <= w_any_neg;
                r_err    <= w_any_inv;
                r_to_cnt <= '0;
                r_stale  <= 1'b0;
            end else if (r_to_cnt != TO_LIM) begin
                r_to_cnt <= r_to_cnt + 1'b1;
                if (r_to_cnt == TO_LIM - 1'b1) begin
                    r_stale <= 1'b1;
                end
            end
        end
    end

    assign codes       = r_codes;
    assign is_neg      = r_is_neg;
    assign err         = r_err;
    assign frame_valid = r_frame_valid;
    assign stale       = r_stale;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans of the 7-segment bus with a frame-level
// reference model; define SCAN_ORDER_CHECK_EN to exercise the order checker.
module tb_seg_scan_decoder;

    localparam int SETTLE = 4;
    localparam int TMO    = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  disp = 8'hFF;
    logic [3:0]  enable = 4'hF;
    logic [15:0] codes;
    logic        is_neg, frame_valid, err, stale;
`ifdef SCAN_ORDER_CHECK_EN
    logic        order_err;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] codes;
        logic        neg;
        logic        err;
    } frame_t;

    // Reference model state
    frame_t      exp_q[$];
    frame_t      last;
    logic [3:0]  m_seen;
    logic [15:0] m_shadow;
    logic [11:0] m_run_pair;
    int          m_run_len;
    int          m_expect;
    int          m_order_errs = 0;
    int          dut_frames = 0;
    int          dut_order_errs = 0;
    int          since = 0;

    seg_scan_decoder #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .disp        (disp),
        .enable      (enable),
        .codes       (codes),
        .is_neg      (is_neg),
        .frame_valid (frame_valid),
        .err         (err),
`ifdef SCAN_ORDER_CHECK_EN
        .order_err   (order_err),
`endif
        .stale       (stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Symbol table written straight from the display code list
    function automatic logic [3:0] sym_of(input logic [6:0] p);
        case (p)
            7'h40: return 4'd0;
            7'h79: return 4'd1;
            7'h24: return 4'd2;
            7'h30: return 4'd3;
            7'h19: return 4'd4;
            7'h12: return 4'd5;
            7'h02: return 4'd6;
            7'h78: return 4'd7;
            7'h00: return 4'd8;
            7'h10: return 4'd9;
            7'h3F: return 4'd10;
            7'h7F: return 4'd11;
            default: return 4'd15;
        endcase
    endfunction

    function automatic bit one_cold(input logic [3:0] en);
        int z;
        z = 0;
        for (int i = 0; i < 4; i++) if (!en[i]) z++;
        return z == 1;
    endfunction

    function automatic int slot_idx(input logic [3:0] en);
        for (int i = 0; i < 4; i++) if (!en[i]) return i;
        return 0;
    endfunction

    task automatic model_capture(input int slot, input logic [3:0] sym);
        frame_t f;
`ifdef SCAN_ORDER_CHECK_EN
        if (slot != m_expect) begin
            m_order_errs++;
            m_seen = 4'h0;
            if (slot != 0) begin
                m_expect = 0;
                return;
            end
        end
        m_expect = (slot + 1) % 4;
`endif
        m_shadow[slot*4 +: 4] = sym;
        m_seen[slot] = 1'b1;
        if (m_seen == 4'hF) begin
            f.codes = m_shadow;
            f.neg   = 1'b0;
            f.err   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_shadow[i*4 +: 4] == 4'd10) f.neg = 1'b1;
                if (m_shadow[i*4 +: 4] == 4'd15) f.err = 1'b1;
            end
            exp_q.push_back(f);
            m_seen = 4'h0;
        end
    endtask

    // A one-cold pair held for SETTLE consecutive clocks is captured exactly once
    task automatic model_cycle(input logic [3:0] en, input logic [7:0] d);
        if ({en, d} == m_run_pair) begin
            m_run_len++;
        end else begin
            m_run_pair = {en, d};
            m_run_len  = 1;
        end
        if (one_cold(en) && m_run_len == SETTLE) model_capture(slot_idx(en), sym_of(d[6:0]));
    endtask

    task automatic apply(input logic [3:0] en, input logic [7:0] d, input int n);
        repeat (n) begin
            @(negedge clk);
            enable = en;
            disp   = d;
            model_cycle(en, d);
        end
    endtask

    // Scan digits 0..3 once, optionally with a short glitch at the start of each slot
    task automatic scan(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [7:0] d3, input int glitch);
        logic [7:0] dv[4];
        logic [3:0] ev[4];
        dv = '{d0, d1, d2, d3};
        ev = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int s = 0; s < 4; s++) begin
            if (glitch > 0) apply(ev[s], 8'hC0, glitch);
            apply(ev[s], dv[s], 8);
        end
        apply(4'hF, 8'hFF, 12);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        enable = 4'hF;
        disp   = 8'hFF;
        m_seen     = 4'h0;
        m_shadow   = 16'hBBBB;
        m_run_pair = {4'hF, 8'hFF};
        m_run_len  = 1;
        m_expect   = 0;
        exp_q.delete();
        #1;
        check("async_reset_codes", codes, 16'hBBBB);
        check("async_reset_stale", stale, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Per-cycle comparison against the model
    initial begin
        last = '{codes: 16'hBBBB, neg: 1'b0, err: 1'b0};
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                since = 0;
                last  = '{codes: 16'hBBBB, neg: 1'b0, err: 1'b0};
                check("rst_frame_valid", frame_valid, 1'b0);
                check("rst_codes", codes, 16'hBBBB);
            end else begin
                if (frame_valid) begin
                    dut_frames++;
                    since = 0;
                    check("frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) last = exp_q.pop_front();
                end else begin
                    since++;
                end
                check("codes", codes, last.codes);
                check("is_neg", is_neg, last.neg);
                check("err", err, last.err);
                check("stale", stale, since >= TMO);
`ifdef SCAN_ORDER_CHECK_EN
                if (order_err) dut_order_errs++;
`endif
            end
        end
    end

    initial begin
        int fc;
        do_reset();
        check("reset_is_neg", is_neg, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_frame_valid", frame_valid, 1'b0);

        // Timeout from reset: stale rises exactly TMO clocks later
        apply(4'hF, 8'hFF, TMO - 1);
        check("stale_at_99", stale, 1'b0);
        apply(4'hF, 8'hFF, 1);
        check("stale_at_100", stale, 1'b1);
        apply(4'hF, 8'hFF, 5);

        // Basic frame; also clears stale
        scan(8'h99, 8'hB0, 8'hA4, 8'hF9, 0);
        check("frame_1234_codes", codes, 16'h1234);
        check("frame_1234_neg", is_neg, 1'b0);
        check("frame_1234_err", err, 1'b0);
        check("frame_1234_stale", stale, 1'b0);
        check("frame_1234_count", dut_frames, 1);

        // Minus in the top digit
        scan(8'h99, 8'hB0, 8'hA4, 8'hBF, 0);
        check("frame_A234_codes", codes, 16'hA234);
        check("frame_A234_neg", is_neg, 1'b1);

        // Two-cycle glitches are ignored; dp lit on digit 3 does not change its symbol
        scan(8'h92, 8'h82, 8'hF8, 8'h00, 2);
        check("glitch_codes", codes, 16'h8765);
        check("glitch_neg", is_neg, 1'b0);

        // Invalid pattern in slot 1, then a clean frame clears err
        scan(8'h99, 8'hD5, 8'hA4, 8'hF9, 0);
        check("invalid_codes", codes, 16'h12F4);
        check("invalid_err", err, 1'b1);
        scan(8'h99, 8'hB0, 8'hA4, 8'hF9, 0);
        check("clean_after_invalid_err", err, 1'b0);

        // Reset after two captures: the earlier captures must not count
        apply(4'b1110, 8'h99, 8);
        apply(4'b1101, 8'hB0, 8);
        do_reset();
        fc = dut_frames;
        apply(4'b1110, 8'hF9, 8);
        apply(4'b1101, 8'hA4, 8);
        apply(4'hF, 8'hFF, 12);
        check("no_frame_after_2_fresh", dut_frames, fc);
        apply(4'b1011, 8'hB0, 8);
        apply(4'b0111, 8'h99, 8);
        apply(4'hF, 8'hFF, 12);
        check("frame_after_4_fresh", dut_frames, fc + 1);
        check("frame_after_reset_codes", codes, 16'h4321);

        // Out-of-order scan 0,2,1,3
        apply(4'b1110, 8'hF8, 8);
        apply(4'b1011, 8'hC0, 8);
        apply(4'hF, 8'hFF, 6);
`ifdef SCAN_ORDER_CHECK_EN
        check("order_err_after_0_2", dut_order_errs, 1);
`endif
        apply(4'b1101, 8'h80, 8);
        apply(4'b0111, 8'h90, 8);
        apply(4'hF, 8'hFF, 12);
`ifdef SCAN_ORDER_CHECK_EN
        check("order_err_total", dut_order_errs, m_order_errs);
        check("order_scan_no_frame", dut_frames, fc + 1);
`else
        check("any_order_codes", codes, 16'h9087);
`endif

        check("expected_frames_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
